// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared constants and types for the scalar pipeline: bank
//               geometry, the PC alias register index and the control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;
    localparam int CTRL_W = 8;

    // Register 15 aliases the PC; its read data is never bypassed
    localparam logic [3:0] PC_REG_IDX = 4'd15;

    localparam int CTRL_REGWRITE_BIT = 0;
    localparam int CTRL_MEMWRITE_BIT = 1;

    // Packed control bundle; upper bits are opaque to this stage
    typedef struct packed {
        logic [CTRL_W-3:0] opaque;
        logic              mem_write;
        logic              reg_write;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/wb_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module      : wb_bypass_mux
// Description : Writeback-to-decode bypass for one register bank read port.
//               Selects the writeback data when this edge's write targets the
//               address being read (the PC alias is excluded).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bypass_mux #(
    parameter int                WIDTH  = 32,
    parameter int                ADDR_W = 4,
    parameter logic [ADDR_W-1:0] PC_IDX = '1
) (
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] ra,
    input  logic [WIDTH-1:0]  rd,
    output logic [WIDTH-1:0]  q
);

    logic w_hit;

    // Address match with an active write, but never on the PC alias
    assign w_hit = we && (wa == ra) && (ra != PC_IDX);
    assign q     = w_hit ? wd : rd;

endmodule
`default_nettype wire

// File: rtl/decode_execute_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : decode_execute_stage_reg
// Description : Decode-to-execute pipeline register with stall, flush,
//               valid tracking and a saturating inserted-bubble counter.
//               Optional macro DECODE_EXECUTE_WB_BYPASS_EN adds writeback
//               bypass on both read operands at load time.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_execute_stage_reg #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic [WIDTH-1:0]  RD1D,
    input  logic [WIDTH-1:0]  RD2D,
    input  logic [WIDTH-1:0]  ImmD,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic              WE3W,
    input  logic [ADDR_W-1:0] A3W,
    input  logic [WIDTH-1:0]  WD3W,
    output logic              ValidE,
    output logic [ADDR_W-1:0] RA1E,
    output logic [ADDR_W-1:0] RA2E,
    output logic [ADDR_W-1:0] WA3E,
    output logic [WIDTH-1:0]  RD1E,
    output logic [WIDTH-1:0]  RD2E,
    output logic [WIDTH-1:0]  ImmE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [CNT_W-1:0]  BubbleCnt
);

    import pipeline_pkg::*;

    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic             w_bubble;

`ifdef DECODE_EXECUTE_WB_BYPASS_EN
    localparam logic [ADDR_W-1:0] c_PC_IDX = ADDR_W'(PC_REG_IDX);

    wb_bypass_mux #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .PC_IDX (c_PC_IDX)
    ) u_byp_rd1 (
        .we (WE3W),
        .wa (A3W),
        .wd (WD3W),
        .ra (RA1D),
        .rd (RD1D),
        .q  (w_rd1)
    );

    wb_bypass_mux #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .PC_IDX (c_PC_IDX)
    ) u_byp_rd2 (
        .we (WE3W),
        .wa (A3W),
        .wd (WD3W),
        .ra (RA2D),
        .rd (RD2D),
        .q  (w_rd2)
    );
`else
    // Without bypass the hazard unit stalls instead; writeback is ignored here
    logic w_unused_wb;
    assign w_unused_wb = ^{WE3W, A3W, WD3W};
    assign w_rd1       = RD1D;
    assign w_rd2       = RD2D;
`endif

    // A bubble enters E on any flush, or on a load of an empty decode slot
    assign w_bubble = FlushE || (!StallE && !ValidD);

    // E-side register: flush clears, stall holds, otherwise load from D
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ValidE <= 1'b0;
            RA1E   <= '0;
            RA2E   <= '0;
            WA3E   <= '0;
            RD1E   <= '0;
            RD2E   <= '0;
            ImmE   <= '0;
            CtrlE  <= '0;
        end else if (FlushE) begin
            ValidE <= 1'b0;
            RA1E   <= '0;
            RA2E   <= '0;
            WA3E   <= '0;
            RD1E   <= '0;
            RD2E   <= '0;
            ImmE   <= '0;
            CtrlE  <= '0;
        end else if (!StallE) begin
            ValidE <= ValidD;
            RA1E   <= RA1D;
            RA2E   <= RA2D;
            WA3E   <= WA3D;
            RD1E   <= w_rd1;
            RD2E   <= w_rd2;
            ImmE   <= ImmD;
            CtrlE  <= ValidD ? CtrlD : '0;
        end
    end

    // Saturating count of inserted bubbles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BubbleCnt <= '0;
        end else if (w_bubble && (BubbleCnt != {CNT_W{1'b1}})) begin
            BubbleCnt <= BubbleCnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/decode_execute_stage_reg.md
Name: decode_execute_stage_reg

Overview:
- Pipeline register between the scalar register bank read ports (decode) and the execute stage.
- Captures the two read operands, their source addresses, the destination address, the immediate and the control bundle every cycle.
- Supports stall (hold), flush (bubble insertion) and a valid bit.
- Counts inserted bubbles for performance debug.

Parameters:
- WIDTH, 32, operand/immediate data width (matches the register bank data width)
- ADDR_W, 4, register address width (16 architectural registers)
- CTRL_W, 8, width of the packed control bundle
- CNT_W, 16, width of the saturating bubble counter

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- StallE  in  1  hold all E-side state this cycle
- FlushE  in  1  insert a bubble this cycle
- ValidD  in  1  decode slot holds a real instruction
- RA1D  in  ADDR_W  read address of port 1
- RA2D  in  ADDR_W  read address of port 2
- WA3D  in  ADDR_W  destination register of the instruction
- RD1D  in  WIDTH  register bank read data, port 1
- RD2D  in  WIDTH  register bank read data, port 2
- ImmD  in  WIDTH  extended immediate
- CtrlD  in  CTRL_W  control bundle (bit0 = RegWrite, bit1 = MemWrite; remaining bits are opaque)
- WE3W  in  1  writeback write enable, same signal that drives the bank's write enable
- A3W  in  ADDR_W  writeback address
- WD3W  in  WIDTH  writeback data
- ValidE  out  1  execute slot holds a real instruction
- RA1E, RA2E, WA3E  out  ADDR_W  registered addresses
- RD1E, RD2E, ImmE  out  WIDTH  registered operands
- CtrlE  out  CTRL_W  registered control bundle
- BubbleCnt  out  CNT_W  number of bubbles inserted since reset

Behaviour:
- Reset: RST high immediately (asynchronously) clears every output to 0, including ValidE, CtrlE and BubbleCnt. State stays cleared while RST is high. The first capture happens on the first rising edge after RST falls.
- Per-edge priority: FlushE > StallE > load.
- Load (neither FlushE nor StallE):
  - All E registers take their D-side values next edge, giving 1-cycle latency.
  - ValidE <= ValidD.
  - CtrlE <= CtrlD when ValidD = 1, otherwise CtrlE <= 0.
- Flush:
  - ValidE <= 0 and CtrlE <= 0.
  - Address and data registers are cleared to 0, so bubbles are deterministic.
  - FlushE together with StallE behaves as a flush; the stall is ignored.
- Stall: every E register, including ValidE, holds. BubbleCnt is unchanged.
- BubbleCnt increments by 1 on each edge where a flush occurs, or where a load occurs with ValidD = 0.
  - It saturates at 2^CNT_W-1 and never wraps.
- No handshake beyond stall/flush. The hazard unit upstream owns the StallE/FlushE timing.
- Address 15 is the PC alias. Its read data is taken verbatim from RD1D/RD2D and is never bypassed.

Optional Feature:
- Macro: DECODE_EXECUTE_WB_BYPASS_EN
- Defined: the bank writes on the clock edge, so a same-cycle read returns the old value. The stage corrects this at load time:
  - If WE3W = 1, A3W == RA1D and RA1D != 15, RD1E captures WD3W instead of RD1D. RD2E follows the same rule using RA2D.
  - Both ports may be bypassed in the same cycle.
  - Bypass applies only on load; stall and flush are unaffected.
- Not defined: RD1E and RD2E always capture RD1D and RD2D. The hazard unit must stall instead.

Decomposition:
- Shared package pipeline_pkg: ADDR_W, WIDTH, PC_REG_IDX = 4'd15, CTRL_REGWRITE_BIT = 0, CTRL_MEMWRITE_BIT = 1, and a packed control typedef ctrl_t.
- One natural sub-module: wb_bypass_mux. It is combinational (address compare + 2:1 select) and instantiated once per read port. It is instantiated only under the macro.

Test Plan:
- Reset mid-operation: load RD1D = 32'hFFFC0007 with ValidD = 1, then assert RST between edges → all outputs 0 immediately, before the next edge. BubbleCnt = 0.
- Basic load: ValidD = 1, RA1D = 1, RA2D = 4, WA3D = 8, RD1D = 32'hAAAAAAAA, CtrlD = 8'h01 → one edge later ValidE = 1, RD1E = 32'hAAAAAAAA, WA3E = 8, CtrlE = 8'h01.
- Stall hold: after the basic load, StallE = 1 for 3 edges while changing RD1D to 32'h12345678 → RD1E stays 32'hAAAAAAAA and BubbleCnt is unchanged.
- Flush vs stall: FlushE = 1 and StallE = 1 on the same edge → ValidE = 0, CtrlE = 0, RD1E = 0, BubbleCnt += 1.
- Bypass (macro defined): RA1D = 1, RA2D = 1, WE3W = 1, A3W = 1, WD3W = 32'hF0000007, RD1D = 32'h0 → RD1E = RD2E = 32'hF0000007.
  - Repeat with RA1D = 15, A3W = 15 → RD1E = RD1D (no bypass).
  - Macro undefined: the same stimulus yields RD1E = 32'h0.
- Saturation: CNT_W = 4, 20 consecutive flushes → BubbleCnt = 15, holds at 15.
